// File: rtl/timing.sv
// Programmable up-counting timer: counts 0..tc_q, emits a one-cycle interrupt
// at terminal count, then stops (one-shot) or reloads to 0 (periodic).
// The terminal count is latched at start acceptance; the mode is sampled live.
module timing #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ro_trig_start,
    input  logic             ro_trig_halt,
    input  logic             ro_mode,
    input  logic [WIDTH-1:0] ro_termcount,
    output logic             rf_status,
    output logic [WIDTH-1:0] rf_currcount,
    output logic             rf_int
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] tc_q;
    logic [WIDTH-1:0] count_q;
    logic             status_q;
    logic             int_q;

    logic             term_hit;
    logic [WIDTH-1:0] count_inc;

    // Terminal detect and incrementer; the counter never passes tc_q, so no wrap.
    always_comb begin
        term_hit  = (count_q == tc_q);
        count_inc = count_q + WIDTH'(1);
    end

    // Timer state machine with registered status, count and interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tc_q     <= '0;
            count_q  <= '0;
            status_q <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            int_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ro_trig_start && !ro_trig_halt) begin
                        tc_q     <= ro_termcount;
                        count_q  <= '0;
                        status_q <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        status_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (ro_trig_halt) begin
                        status_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (term_hit) begin
                        int_q <= 1'b1;
                        if (!ro_mode) begin
                            status_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            count_q <= '0;
                        end
                    end else begin
                        count_q <= count_inc;
                    end
                end
                default: begin
                    status_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign rf_status    = status_q;
    assign rf_currcount = count_q;
    assign rf_int       = int_q;

endmodule

// File: tb/tb_timing.sv
// Directed bench for the timing block: one task per scenario, inline checks.
module tb_timing;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             ro_trig_start;
    logic             ro_trig_halt;
    logic             ro_mode;
    logic [WIDTH-1:0] ro_termcount;
    logic             rf_status;
    logic [WIDTH-1:0] rf_currcount;
    logic             rf_int;

    int n_cmp = 0;
    int n_err = 0;

    timing #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .ro_trig_start(ro_trig_start),
        .ro_trig_halt (ro_trig_halt),
        .ro_mode      (ro_mode),
        .ro_termcount (ro_termcount),
        .rf_status    (rf_status),
        .rf_currcount (rf_currcount),
        .rf_int       (rf_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs are changed and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ro_trig_start = 1'b0; ro_trig_halt = 1'b0;
        ro_mode = 1'b0; ro_termcount = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({rf_status, rf_int} !== 2'b00 || rf_currcount !== 32'd0) begin
            n_err++;
            $display("FAIL reset_hold: status=%0b int=%0b count=%0d want 0 0 0", rf_status, rf_int, rf_currcount);
        end
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({rf_status, rf_int} !== 2'b00 || rf_currcount !== 32'd0) begin
            n_err++;
            $display("FAIL idle_no_start: status=%0b int=%0b count=%0d want 0 0 0", rf_status, rf_int, rf_currcount);
        end
    endtask

    task automatic test_oneshot();
        ro_mode = 1'b0; ro_termcount = 32'd10; ro_trig_start = 1'b1;
        tick();
        ro_trig_start = 1'b0;
        n_cmp++;
        if (rf_status !== 1'b1 || rf_currcount !== 32'd0 || rf_int !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_accept: status=%0b count=%0d int=%0b want 1 0 0", rf_status, rf_currcount, rf_int);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++;
            if (rf_status !== 1'b1 || rf_currcount !== 32'(i) || rf_int !== 1'b0) begin
                n_err++;
                $display("FAIL oneshot_count%0d: status=%0b count=%0d int=%0b want 1 %0d 0", i, rf_status, rf_currcount, rf_int, i);
            end
        end
        tick();
        n_cmp++;
        if (rf_int !== 1'b1 || rf_status !== 1'b0 || rf_currcount !== 32'd10) begin
            n_err++;
            $display("FAIL oneshot_term: int=%0b status=%0b count=%0d want 1 0 10", rf_int, rf_status, rf_currcount);
        end
        tick();
        n_cmp++;
        if (rf_int !== 1'b0 || rf_status !== 1'b0 || rf_currcount !== 32'd10) begin
            n_err++;
            $display("FAIL oneshot_after: int=%0b status=%0b count=%0d want 0 0 10", rf_int, rf_status, rf_currcount);
        end
    endtask

    task automatic test_periodic();
        ro_mode = 1'b1; ro_termcount = 32'd3; ro_trig_start = 1'b1;
        tick();
        ro_trig_start = 1'b0;
        n_cmp++;
        if (rf_status !== 1'b1 || rf_currcount !== 32'd0) begin
            n_err++;
            $display("FAIL periodic_accept: status=%0b count=%0d want 1 0", rf_status, rf_currcount);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_cmp++;
            if (rf_status !== 1'b1 || rf_currcount !== 32'(i % 4) || rf_int !== ((i % 4) == 0)) begin
                n_err++;
                $display("FAIL periodic_step%0d: status=%0b count=%0d int=%0b want 1 %0d %0b", i, rf_status, rf_currcount, rf_int, i % 4, (i % 4) == 0);
            end
        end
        ro_trig_halt = 1'b1;
        tick();
        ro_trig_halt = 1'b0;
        n_cmp++;
        if (rf_status !== 1'b0 || rf_currcount !== 32'd1 || rf_int !== 1'b0) begin
            n_err++;
            $display("FAIL periodic_halt: status=%0b count=%0d int=%0b want 0 1 0", rf_status, rf_currcount, rf_int);
        end
    endtask

    task automatic test_halt();
        ro_mode = 1'b0; ro_termcount = 32'd10; ro_trig_start = 1'b1;
        tick();
        ro_trig_start = 1'b0;
        repeat (5) tick();
        ro_trig_halt = 1'b1;
        tick();
        ro_trig_halt = 1'b0;
        n_cmp++;
        if (rf_status !== 1'b0 || rf_currcount !== 32'd5 || rf_int !== 1'b0) begin
            n_err++;
            $display("FAIL halt_freeze: status=%0b count=%0d int=%0b want 0 5 0", rf_status, rf_currcount, rf_int);
        end
        repeat (3) tick();
        n_cmp++;
        if (rf_status !== 1'b0 || rf_currcount !== 32'd5 || rf_int !== 1'b0) begin
            n_err++;
            $display("FAIL halt_hold: status=%0b count=%0d int=%0b want 0 5 0", rf_status, rf_currcount, rf_int);
        end
        ro_trig_start = 1'b1;
        tick();
        ro_trig_start = 1'b0;
        n_cmp++;
        if (rf_status !== 1'b1 || rf_currcount !== 32'd0) begin
            n_err++;
            $display("FAIL halt_restart: status=%0b count=%0d want 1 0", rf_status, rf_currcount);
        end
        tick();
        ro_trig_halt = 1'b1;
        tick();
        ro_trig_halt = 1'b0;
    endtask

    task automatic test_start_halt();
        ro_trig_start = 1'b1; ro_trig_halt = 1'b1;
        tick();
        ro_trig_start = 1'b0; ro_trig_halt = 1'b0;
        n_cmp++;
        if (rf_status !== 1'b0 || rf_currcount !== 32'd1) begin
            n_err++;
            $display("FAIL start_halt_idle: status=%0b count=%0d want 0 1", rf_status, rf_currcount);
        end
        ro_mode = 1'b0; ro_termcount = 32'd4; ro_trig_start = 1'b1;
        tick();
        ro_trig_start = 1'b0;
        ro_termcount = 32'd2;
        ro_trig_start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (rf_status !== 1'b1 || rf_currcount !== 32'(i) || rf_int !== 1'b0) begin
                n_err++;
                $display("FAIL run_restart_ignored%0d: status=%0b count=%0d int=%0b want 1 %0d 0", i, rf_status, rf_currcount, rf_int, i);
            end
        end
        ro_trig_start = 1'b0;
        tick();
        n_cmp++;
        if (rf_int !== 1'b1 || rf_status !== 1'b0 || rf_currcount !== 32'd4) begin
            n_err++;
            $display("FAIL latched_tc_term: int=%0b status=%0b count=%0d want 1 0 4", rf_int, rf_status, rf_currcount);
        end
    endtask

    task automatic test_mode_live();
        ro_mode = 1'b1; ro_termcount = 32'd2; ro_trig_start = 1'b1;
        tick();
        ro_trig_start = 1'b0;
        repeat (2) tick();
        ro_mode = 1'b0;
        tick();
        n_cmp++;
        if (rf_int !== 1'b1 || rf_status !== 1'b0 || rf_currcount !== 32'd2) begin
            n_err++;
            $display("FAIL mode_live_stop: int=%0b status=%0b count=%0d want 1 0 2", rf_int, rf_status, rf_currcount);
        end
    endtask

    task automatic test_back_to_back();
        // tc=0 one-shot with start held: accept, pulse, re-accept, pulse.
        ro_mode = 1'b0; ro_termcount = 32'd0; ro_trig_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (rf_status !== ((i % 2) == 0) || rf_int !== ((i % 2) == 1) || rf_currcount !== 32'd0) begin
                n_err++;
                $display("FAIL tc0_held%0d: status=%0b int=%0b count=%0d want %0b %0b 0", i, rf_status, rf_int, rf_currcount, (i % 2) == 0, (i % 2) == 1);
            end
        end
        ro_trig_start = 1'b0;
        tick();
        n_cmp++;
        if (rf_status !== 1'b0 || rf_int !== 1'b0) begin
            n_err++;
            $display("FAIL tc0_settle: status=%0b int=%0b want 0 0", rf_status, rf_int);
        end
    endtask

    task automatic test_async_reset();
        // Periodic tc=0 holds rf_int high; reset between edges must drop everything.
        ro_mode = 1'b1; ro_termcount = 32'd0; ro_trig_start = 1'b1;
        tick();
        ro_trig_start = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++;
            if (rf_int !== 1'b1 || rf_status !== 1'b1) begin
                n_err++;
                $display("FAIL tc0_periodic: int=%0b status=%0b want 1 1", rf_int, rf_status);
            end
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({rf_status, rf_int} !== 2'b00 || rf_currcount !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset_pulse: status=%0b int=%0b count=%0d want 0 0 0", rf_status, rf_int, rf_currcount);
        end
        #1 reset = 1'b1;
        tick();
        ro_mode = 1'b0; ro_termcount = 32'd10; ro_trig_start = 1'b1;
        tick();
        ro_trig_start = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({rf_status, rf_int} !== 2'b00 || rf_currcount !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset_count: status=%0b int=%0b count=%0d want 0 0 0", rf_status, rf_int, rf_currcount);
        end
        #1 reset = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (rf_status !== 1'b0 || rf_currcount !== 32'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: status=%0b count=%0d want 0 0", rf_status, rf_currcount);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_halt();
        test_start_halt();
        test_mode_live();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
